// File: rtl/hazard_forward_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types for the pipeline hazard / forwarding controller:
//                EX operand select encoding, controller FSM states and a
//                helper sizing the load-use bubble counter.
//  Revision    : 1.0  initial release
// ============================================================================
package hazard_pkg;

    // EX operand mux select; the encoding is visible on fwd_sel.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // Controller states: normal flow, extra load-use bubbles, data-memory wait.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_WAIT  = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_e;

    // The bubble counter only has to hold LOAD_LAT-1; keep it at least 1 bit wide.
    function automatic int unsigned lu_cnt_width(int unsigned load_lat);
        return (load_lat > 1) ? $clog2(load_lat) : 1;
    endfunction

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_forward_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_forward_ctrl_if
//  Description : Bundle of pipeline-stage hazard inputs and the stall, flush,
//                bubble and forwarding controls returned by the controller.
//                master = pipeline side, slave = hazard controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface hazard_forward_ctrl_if #(
    parameter int AW     = 5,
    parameter int NPORTS = 2,
    parameter int CNT_W  = 32
) ();

    // ID stage
    logic [NPORTS-1:0][AW-1:0] rs_id;
    logic [NPORTS-1:0]         rs_used_id;
    // EX stage
    logic [NPORTS-1:0][AW-1:0] rs_ex;
    logic [AW-1:0]             rd_ex;
    logic                      reg_write_ex;
    logic                      mem_read_ex;
    logic                      branch_taken_ex;
    // MEM stage
    logic [AW-1:0]             rd_mem;
    logic                      reg_write_mem;
    logic                      mem_req_mem;
    logic                      dmem_ready;
    // WB stage
    logic [AW-1:0]             rd_wb;
    logic                      reg_write_wb;
    // Controls back to the pipeline
    logic [NPORTS-1:0][1:0]    fwd_sel;
    logic                      stall_if;
    logic                      stall_id;
    logic                      stall_ex;
    logic                      stall_mem;
    logic                      bubble_ex;
    logic                      flush_id;
    logic [CNT_W-1:0]          stall_cnt;

    modport master (
        output rs_id, rs_used_id, rs_ex, rd_ex, reg_write_ex, mem_read_ex,
               branch_taken_ex, rd_mem, reg_write_mem, mem_req_mem, dmem_ready,
               rd_wb, reg_write_wb,
        input  fwd_sel, stall_if, stall_id, stall_ex, stall_mem, bubble_ex,
               flush_id, stall_cnt
    );

    modport slave (
        input  rs_id, rs_used_id, rs_ex, rd_ex, reg_write_ex, mem_read_ex,
               branch_taken_ex, rd_mem, reg_write_mem, mem_req_mem, dmem_ready,
               rd_wb, reg_write_wb,
        output fwd_sel, stall_if, stall_id, stall_ex, stall_mem, bubble_ex,
               flush_id, stall_cnt
    );

endinterface : hazard_forward_ctrl_if
`default_nettype wire

// File: rtl/hazard_forward_ctrl_fwd_port_sel.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_port_sel
//  Description : Forwarding select for one EX source operand. A younger
//                result in MEM wins over an older one in WB; writes to x0
//                are never forwarded.
//  Revision    : 1.0  initial release
// ============================================================================
module fwd_port_sel
    import hazard_pkg::*;
#(
    parameter int AW = 5
) (
    input  wire logic [AW-1:0] rs_ex,
    input  wire logic [AW-1:0] rd_mem,
    input  wire logic          reg_write_mem,
    input  wire logic [AW-1:0] rd_wb,
    input  wire logic          reg_write_wb,
    output fwd_sel_e           sel
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = reg_write_mem && (rd_mem != '0) && (rd_mem == rs_ex);
    assign wb_hit  = reg_write_wb  && (rd_wb  != '0) && (rd_wb  == rs_ex);

    // Priority select: MEM result is newer than the WB result.
    always_comb begin
        sel = FWD_RF;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule : fwd_port_sel
`default_nettype wire

// File: rtl/hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_forward_ctrl
//  Description : Hazard controller for the 5-stage core. Drives EX operand
//                forwarding, load-use stalls with LOAD_LAT bubbles, data
//                memory wait stalls, branch flush and a saturating count of
//                front-end stall cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int AW       = 5,
    parameter int NPORTS   = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    hazard_forward_ctrl_if.slave bus
);

    localparam int unsigned LCW = lu_cnt_width(LOAD_LAT);

    hz_state_e        state_q, state_d;
    logic [LCW-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic flush_req;
    logic mem_wait;
    logic lu_hit;
    logic lu_match;

    logic stall_if_c, stall_id_c, stall_ex_c, stall_mem_c;
    logic bubble_c, flush_c;

    // ------------------------------------------------------------------
    // Per-port forwarding compare
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
        fwd_sel_e port_sel;

        fwd_port_sel #(
            .AW (AW)
        ) u_fwd_port_sel (
            .rs_ex         (bus.rs_ex[gi]),
            .rd_mem        (bus.rd_mem),
            .reg_write_mem (bus.reg_write_mem),
            .rd_wb         (bus.rd_wb),
            .reg_write_wb  (bus.reg_write_wb),
            .sel           (port_sel)
        );

        assign bus.fwd_sel[gi] = port_sel;
    end

    // ------------------------------------------------------------------
    // Hazard conditions
    // ------------------------------------------------------------------
    assign flush_req = bus.branch_taken_ex;
    assign mem_wait  = bus.mem_req_mem && !bus.dmem_ready;

    // Any ID port that really reads the register the EX load is producing.
    always_comb begin
        lu_match = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            if (bus.rs_used_id[i] && (bus.rs_id[i] == bus.rd_ex)) begin
                lu_match = 1'b1;
            end
        end
    end

    assign lu_hit = bus.mem_read_ex && bus.reg_write_ex &&
                    (bus.rd_ex != '0) && lu_match;

    // ------------------------------------------------------------------
    // FSM next-state and control decode (flush > mem wait > load-use)
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_if_c  = 1'b0;
        stall_id_c  = 1'b0;
        stall_ex_c  = 1'b0;
        stall_mem_c = 1'b0;
        bubble_c    = 1'b0;
        flush_c     = 1'b0;

        case (state_q)
            RUN: begin
                if (flush_req) begin
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                end else if (mem_wait) begin
                    stall_if_c  = 1'b1;
                    stall_id_c  = 1'b1;
                    stall_ex_c  = 1'b1;
                    stall_mem_c = 1'b1;
                    state_d     = MEM_WAIT;
                end else if (lu_hit) begin
                    stall_if_c = 1'b1;
                    stall_id_c = 1'b1;
                    bubble_c   = 1'b1;
                    // First bubble is this cycle; LU_WAIT covers the rest.
                    if (LOAD_LAT > 1) begin
                        cnt_d   = LCW'(LOAD_LAT - 1);
                        state_d = LU_WAIT;
                    end
                end
            end

            LU_WAIT: begin
                if (flush_req) begin
                    // The dependent instruction is squashed, so stop bubbling.
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                    cnt_d    = '0;
                    state_d  = RUN;
                end else begin
                    stall_if_c = 1'b1;
                    stall_id_c = 1'b1;
                    bubble_c   = 1'b1;
                    cnt_d      = cnt_q - LCW'(1);
                    if (cnt_q == LCW'(1)) begin
                        state_d = RUN;
                    end
                end
            end

            MEM_WAIT: begin
                if (!bus.dmem_ready) begin
                    stall_if_c  = 1'b1;
                    stall_id_c  = 1'b1;
                    stall_ex_c  = 1'b1;
                    stall_mem_c = 1'b1;
                end else begin
                    // EX was frozen; a branch held there can now flush.
                    state_d = RUN;
                    if (flush_req) begin
                        flush_c  = 1'b1;
                        bubble_c = 1'b1;
                    end
                end
            end

            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Saturating count of cycles the front end was held.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_if_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State, bubble counter and stall counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_if  = stall_if_c;
    assign bus.stall_id  = stall_id_c;
    assign bus.stall_ex  = stall_ex_c;
    assign bus.stall_mem = stall_mem_c;
    assign bus.bubble_ex = bubble_c;
    assign bus.flush_id  = flush_c;
    assign bus.stall_cnt = stall_cnt_q;

endmodule : hazard_forward_ctrl
`default_nettype wire

// File: tb/tb_hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_forward_ctrl
//  Description : Self-checking bench. Two controllers (LOAD_LAT=1/CNT_W=32
//                and LOAD_LAT=3/CNT_W=4) see identical stimulus; a reference
//                model pushes expected controls into a scoreboard queue and
//                a monitor compares them against both instances.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_forward_ctrl;

    localparam int AW = 5;
    localparam int NP = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Shared stimulus
    logic [NP-1:0][AW-1:0] rs_id, rs_ex;
    logic [NP-1:0]         rs_used_id;
    logic [AW-1:0]         rd_ex, rd_mem, rd_wb;
    logic                  reg_write_ex, mem_read_ex, branch_taken_ex;
    logic                  reg_write_mem, mem_req_mem, dmem_ready, reg_write_wb;

    hazard_forward_ctrl_if #(.AW(AW), .NPORTS(NP), .CNT_W(32)) bus0 ();
    hazard_forward_ctrl_if #(.AW(AW), .NPORTS(NP), .CNT_W(4))  bus1 ();

    hazard_forward_ctrl #(.AW(AW), .NPORTS(NP), .LOAD_LAT(1), .CNT_W(32)) u_dut0 (
        .clk (clk), .rst_n (rst_n), .bus (bus0.slave)
    );
    hazard_forward_ctrl #(.AW(AW), .NPORTS(NP), .LOAD_LAT(3), .CNT_W(4)) u_dut1 (
        .clk (clk), .rst_n (rst_n), .bus (bus1.slave)
    );

    always_comb begin
        bus0.rs_id = rs_id;           bus1.rs_id = rs_id;
        bus0.rs_used_id = rs_used_id; bus1.rs_used_id = rs_used_id;
        bus0.rs_ex = rs_ex;           bus1.rs_ex = rs_ex;
        bus0.rd_ex = rd_ex;           bus1.rd_ex = rd_ex;
        bus0.reg_write_ex = reg_write_ex;   bus1.reg_write_ex = reg_write_ex;
        bus0.mem_read_ex = mem_read_ex;     bus1.mem_read_ex = mem_read_ex;
        bus0.branch_taken_ex = branch_taken_ex; bus1.branch_taken_ex = branch_taken_ex;
        bus0.rd_mem = rd_mem;               bus1.rd_mem = rd_mem;
        bus0.reg_write_mem = reg_write_mem; bus1.reg_write_mem = reg_write_mem;
        bus0.mem_req_mem = mem_req_mem;     bus1.mem_req_mem = mem_req_mem;
        bus0.dmem_ready = dmem_ready;       bus1.dmem_ready = dmem_ready;
        bus0.rd_wb = rd_wb;                 bus1.rd_wb = rd_wb;
        bus0.reg_write_wb = reg_write_wb;   bus1.reg_write_wb = reg_write_wb;
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int         d;
        int         cyc;
        bit         chk_ctrl;
        logic [1:0] fwd [NP];
        bit         sif, sid, sex, smem, bub, fl;
        longint     scnt;
    } exp_t;

    exp_t sbq [$];
    int   nchk = 0;
    int   nerr = 0;
    int   cyc  = 0;

    // Reference state per instance: bubbles still owed, memory-wait flag, stall count.
    int     lu_left [2];
    bit     in_mw   [2];
    longint scnt    [2];
    int     n_lu_left [2];
    bit     n_in_mw   [2];
    longint n_scnt    [2];

    function automatic logic [1:0] fwd_of(logic [AW-1:0] rs);
        if (reg_write_mem && rd_mem != 0 && rd_mem == rs) return 2'b10;
        if (reg_write_wb  && rd_wb  != 0 && rd_wb  == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_eval(int d);
        exp_t   e;
        int     lat  = (d == 0) ? 1 : 3;
        int     cw   = (d == 0) ? 32 : 4;
        longint maxc = (longint'(1) << cw) - 1;
        bit     hit  = 1'b0;
        bit     mwait = mem_req_mem && !dmem_ready;
        e.d = d; e.cyc = cyc;
        e.sif = 0; e.sid = 0; e.sex = 0; e.smem = 0; e.bub = 0; e.fl = 0;
        for (int i = 0; i < NP; i++) e.fwd[i] = fwd_of(rs_ex[i]);
        if (mem_read_ex && reg_write_ex && rd_ex != 0)
            for (int i = 0; i < NP; i++)
                if (rs_used_id[i] && rs_id[i] == rd_ex) hit = 1'b1;
        n_lu_left[d] = lu_left[d];
        n_in_mw[d]   = in_mw[d];
        if (in_mw[d]) begin
            if (!dmem_ready) begin
                e.sif = 1; e.sid = 1; e.sex = 1; e.smem = 1;
            end else begin
                n_in_mw[d] = 0;
                if (branch_taken_ex) begin e.fl = 1; e.bub = 1; end
            end
        end else if (lu_left[d] > 0) begin
            if (branch_taken_ex) begin
                e.fl = 1; e.bub = 1; n_lu_left[d] = 0;
            end else begin
                e.sif = 1; e.sid = 1; e.bub = 1; n_lu_left[d] = lu_left[d] - 1;
            end
        end else if (branch_taken_ex) begin
            e.fl = 1; e.bub = 1;
        end else if (mwait) begin
            e.sif = 1; e.sid = 1; e.sex = 1; e.smem = 1; n_in_mw[d] = 1;
        end else if (hit) begin
            e.sif = 1; e.sid = 1; e.bub = 1; n_lu_left[d] = lat - 1;
        end
        e.scnt    = scnt[d];
        n_scnt[d] = (e.sif && scnt[d] < maxc) ? scnt[d] + 1 : scnt[d];
        e.chk_ctrl = rst_n;
        if (!rst_n) begin
            n_lu_left[d] = 0; n_in_mw[d] = 0; n_scnt[d] = 0;
        end
        sbq.push_back(e);
    endtask

    task automatic step();
        model_eval(0);
        model_eval(1);
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            lu_left[d] = n_lu_left[d]; in_mw[d] = n_in_mw[d]; scnt[d] = n_scnt[d];
        end
        cyc++;
        #1;
    endtask

    task automatic idle();
        rs_id = '0; rs_ex = '0; rs_used_id = '0;
        rd_ex = '0; rd_mem = '0; rd_wb = '0;
        reg_write_ex = 0; mem_read_ex = 0; branch_taken_ex = 0;
        reg_write_mem = 0; mem_req_mem = 0; dmem_ready = 1; reg_write_wb = 0;
    endtask

    // ------------------------------------------------------------------
    // Monitor: outputs are valid every cycle, sampled mid-cycle.
    // ------------------------------------------------------------------
    task automatic check(string name, int d, int c, logic [63:0] act, logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, d, c, act, exp);
        end
    endtask

    exp_t m;
    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            m = sbq.pop_front();
            if (m.d == 0) begin
                for (int i = 0; i < NP; i++) check($sformatf("fwd_sel[%0d]", i), 0, m.cyc, 64'(bus0.fwd_sel[i]), 64'(m.fwd[i]));
                if (m.chk_ctrl) begin
                    check("stall_if", 0, m.cyc, 64'(bus0.stall_if), 64'(m.sif));
                    check("stall_id", 0, m.cyc, 64'(bus0.stall_id), 64'(m.sid));
                    check("stall_ex", 0, m.cyc, 64'(bus0.stall_ex), 64'(m.sex));
                    check("stall_mem", 0, m.cyc, 64'(bus0.stall_mem), 64'(m.smem));
                    check("bubble_ex", 0, m.cyc, 64'(bus0.bubble_ex), 64'(m.bub));
                    check("flush_id", 0, m.cyc, 64'(bus0.flush_id), 64'(m.fl));
                    check("stall_cnt", 0, m.cyc, 64'(bus0.stall_cnt), 64'(m.scnt));
                end
            end else begin
                for (int i = 0; i < NP; i++) check($sformatf("fwd_sel[%0d]", i), 1, m.cyc, 64'(bus1.fwd_sel[i]), 64'(m.fwd[i]));
                if (m.chk_ctrl) begin
                    check("stall_if", 1, m.cyc, 64'(bus1.stall_if), 64'(m.sif));
                    check("stall_id", 1, m.cyc, 64'(bus1.stall_id), 64'(m.sid));
                    check("stall_ex", 1, m.cyc, 64'(bus1.stall_ex), 64'(m.sex));
                    check("stall_mem", 1, m.cyc, 64'(bus1.stall_mem), 64'(m.smem));
                    check("bubble_ex", 1, m.cyc, 64'(bus1.bubble_ex), 64'(m.bub));
                    check("flush_id", 1, m.cyc, 64'(bus1.flush_id), 64'(m.fl));
                    check("stall_cnt", 1, m.cyc, 64'(bus1.stall_cnt), 64'(m.scnt));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic load_use(bit used);
        idle();
        mem_read_ex = 1; reg_write_ex = 1; rd_ex = 5'd7;
        rs_id[1] = 5'd7; rs_used_id[1] = used;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin lu_left[d] = 0; in_mw[d] = 0; scnt[d] = 0; end
        idle();
        rst_n = 0;
        step(); step();
        rst_n = 1;
        step();

        // Forwarding priority: MEM, then WB, then register file.
        rs_ex[0] = 5'd5; rd_mem = 5'd5; reg_write_mem = 1; rd_wb = 5'd5; reg_write_wb = 1;
        step();
        rd_mem = 5'd0; step();
        rd_wb  = 5'd0; step();
        idle(); step();

        // Load-use on port 1, then same registers with the port unused.
        load_use(1); step();
        idle(); step(); step(); step();
        load_use(0); step();
        idle(); step();

        // Load-use then a taken branch in the second bubble cycle.
        load_use(1); step();
        idle(); branch_taken_ex = 1; step();
        idle(); step(); step();

        // Data-memory wait for 4 cycles, then completion.
        mem_req_mem = 1; dmem_ready = 0;
        repeat (4) step();
        dmem_ready = 1; step();
        idle(); step();

        // Reset in the middle of LU_WAIT.
        load_use(1); step();
        idle(); step();
        rst_n = 0; step();
        rst_n = 1; step(); step();

        // Long memory wait: 4-bit counter must saturate.
        mem_req_mem = 1; dmem_ready = 0;
        repeat (20) step();
        dmem_ready = 1; step();
        idle(); step();

        // Randomised traffic on a small register range so matches are frequent.
        repeat (500) begin
            for (int i = 0; i < NP; i++) begin
                rs_id[i] = AW'($urandom_range(0, 7));
                rs_ex[i] = AW'($urandom_range(0, 7));
            end
            rs_used_id      = NP'($urandom);
            rd_ex           = AW'($urandom_range(0, 7));
            rd_mem          = AW'($urandom_range(0, 7));
            rd_wb           = AW'($urandom_range(0, 7));
            reg_write_ex    = ($urandom_range(0, 3) != 0);
            mem_read_ex     = ($urandom_range(0, 1) != 0);
            reg_write_mem   = ($urandom_range(0, 1) != 0);
            reg_write_wb    = ($urandom_range(0, 1) != 0);
            mem_req_mem     = ($urandom_range(0, 3) == 0);
            dmem_ready      = ($urandom_range(0, 1) != 0);
            branch_taken_ex = ($urandom_range(0, 7) == 0);
            rst_n           = ($urandom_range(0, 49) != 0);
            step();
        end
        rst_n = 1;
        idle(); step();

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule : tb_hazard_forward_ctrl
`default_nettype wire

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Pipeline hazard controller for the 5-stage core. It generalises EX-stage operand forwarding to `NPORTS` source ports of `AW`-bit register addresses. It adds load-use stall detection with configurable bubble count, data-memory wait stalls, branch flush, and a saturating stall-cycle counter. It sits beside the ID/EX/MEM/WB pipeline registers and drives their enable, flush and bubble controls plus the EX operand muxes.

## Interface
- `AW`, 5, register address width
- `NPORTS`, 2, source operand ports per instruction
- `LOAD_LAT`, 1, bubble cycles needed between a load in EX and a dependent consumer (≥1)
- `CNT_W`, 32, stall counter width

- `clk`  in  1  clock
- `rst_n`  in  1  synchronous, active-low reset
- `rs_id`  in  [NPORTS][AW]  ID-stage source registers
- `rs_used_id`  in  NPORTS  ID-stage port actually reads its register
- `rs_ex`  in  [NPORTS][AW]  EX-stage source registers
- `rd_ex`, `reg_write_ex`, `mem_read_ex`  in  AW,1,1  EX-stage destination, write enable, load flag
- `rd_mem`, `reg_write_mem`, `mem_req_mem`  in  AW,1,1  MEM-stage destination, write enable, memory request
- `dmem_ready`  in  1  data memory completes MEM access this cycle
- `rd_wb`, `reg_write_wb`  in  AW,1  WB-stage destination, write enable
- `branch_taken_ex`  in  1  EX resolves a taken branch/jump
- `fwd_sel`  out  [NPORTS][2]  EX operand select: 00 regfile, 01 WB, 10 MEM
- `stall_if`, `stall_id`  out  1  hold PC / IF-ID register
- `stall_ex`, `stall_mem`  out  1  hold ID-EX / EX-MEM register
- `bubble_ex`  out  1  load NOP into ID-EX
- `flush_id`  out  1  load NOP into IF-ID
- `stall_cnt`  out  CNT_W  stall cycles since reset

## Operation
- Forwarding, per port i, combinational: MEM when `reg_write_mem && rd_mem!=0 && rd_mem==rs_ex[i]`; else WB when `reg_write_wb && rd_wb!=0 && rd_wb==rs_ex[i]`; else regfile. MEM has priority over WB.
- Load-use hit: `mem_read_ex && reg_write_ex && rd_ex!=0`, and some i with `rs_used_id[i] && rs_id[i]==rd_ex`.
- Mem wait: `mem_req_mem && !dmem_ready`.
- FSM states are `RUN`, `LU_WAIT` and `MEM_WAIT`. Priority: flush > mem wait > load-use.
- RUN:
  - On a flush, assert `flush_id` and `bubble_ex`, and stay in RUN.
  - On a mem wait, assert all four stalls and go to MEM_WAIT.
  - On a load-use hit, assert `stall_if`, `stall_id` and `bubble_ex`. If `LOAD_LAT>1`, load `cnt=LOAD_LAT-1` and go to LU_WAIT.
- LU_WAIT:
  - Assert `stall_if`, `stall_id` and `bubble_ex`, and decrement `cnt`.
  - When `cnt==1` this cycle, go to RUN next cycle.
  - Hazard detection is not re-evaluated in this state.
- MEM_WAIT:
  - Assert all four stalls and no bubble while `!dmem_ready`.
  - The cycle `dmem_ready` rises, deassert the stalls and go to RUN.
  - A pending load-use is re-evaluated from RUN on the next cycle.
- Flush while in LU_WAIT or MEM_WAIT:
  - In LU_WAIT, a flush aborts it: `cnt` clears and the FSM goes to RUN.
  - In MEM_WAIT, the flush is held off until `dmem_ready`, because EX is frozen.
- The register file is write-first, so no forwarding is needed past WB.
- `stall_cnt` increments on every cycle `stall_if` is 1 and saturates at all-ones.

## Timing
- `fwd_sel`, stalls, bubble and flush are combinational from the inputs and state. There are no added cycles.
- State, `cnt` and `stall_cnt` update on the rising edge of `clk`.
- A load-use hit produces exactly `LOAD_LAT` consecutive stall/bubble cycles, starting the cycle of detection.
- Reset (`rst_n=0` at an edge, including mid-stall):
  - state goes to RUN, `cnt` to 0, `stall_cnt` to 0.
  - Outputs after reset: all stalls, `bubble_ex` and `flush_id` are 0. `fwd_sel` follows the inputs.

## Structure
- `hazard_pkg` holds:
  - `fwd_sel_e` with `FWD_RF=2'b00`, `FWD_WB=2'b01`, `FWD_MEM=2'b10`.
  - `hz_state_e` with RUN, LU_WAIT and MEM_WAIT.
- Sub-module `fwd_port_sel` contains the per-port forwarding compare. It is generated `NPORTS` times.
- The FSM, counters and output decode live in the top level.

## Test plan
- `rs_ex[0]=5`, `rd_mem=5`/`reg_write_mem=1`, `rd_wb=5`/`reg_write_wb=1` -> `fwd_sel[0]=10`. With `rd_mem=0` instead -> `01`. With `rd_wb=0` as well -> `00`.
- Load `rd_ex=7`, `rs_id[1]=7`:
  - With `rs_used_id[1]=1`, `LOAD_LAT=1` -> one cycle of `stall_if`/`stall_id`/`bubble_ex`, and `stall_cnt` 0->1.
  - With `rs_used_id[1]=0` -> no stall.
- With `LOAD_LAT=3` and a load-use hit -> exactly 3 bubble cycles. A `branch_taken_ex` in cycle 2 -> `flush_id`, return to RUN, and no third bubble.
- `mem_req_mem=1`, `dmem_ready=0` for 4 cycles -> all four stalls high for 4 cycles, `bubble_ex=0`, and stalls released the cycle `dmem_ready=1`.
- Apply reset in the middle of LU_WAIT -> all control outputs 0 on the next cycle and `stall_cnt=0`.
- With `CNT_W=4` and 20 stall cycles -> `stall_cnt` holds at 15.
